usb_tx_packet_engine: RTL and testbench

//  Parametrised USB full-speed packet transmitter: serialises SYNC, PID, N payload bytes and optional CRC16.

---
 rtl/usb_tx_packet_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_usb_tx_packet_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_packet_engine.sv
// USB full-speed TX: SYNC, PID, payload, optional CRC16, bit stuffing, NRZI, EOP onto registered D+/D-.
// One USB bit per CLKS_PER_BIT clks; payload popped from an FWFT FIFO one byte at a time; an empty FIFO ends the packet early.
module usb_tx_packet_engine #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int MAX_BYTES    = 64,
    parameter int EOP_SE0_BITS = 2,
    parameter int LEN_W        = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             N_reset,
    input  logic             tx_start,
    input  logic [7:0]       tx_pid,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             crc_en,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             err_underrun,
    output logic             D_Plus_Out,
    output logic             D_Minus_Out
);
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0] STUFF_AT  = ONES_W'(STUFF_LEN);
    localparam logic [4:0]        EOP_LAST  = 5'(EOP_SE0_BITS);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_BYTES);
    localparam logic [7:0]        SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [4:0]        bit_cnt, bit_cnt_n;
    logic [15:0]       sr, sr_n;
    logic [ONES_W-1:0] ones, ones_n;
    logic [LEN_W-1:0]  bytes_left, bytes_n;
    logic [15:0]       crc, crc_n;
    logic [7:0]        pid_q, pid_n;
    logic              crc_en_q, crc_en_n;
    logic              nrzi_j, nrzi_n;
    logic              dp_q, dp_n, dm_q, dm_n;
    logic              busy_n, done_n, ready_n, urun_n;
    logic              strobe, stuff_due, field_last;
    logic              emit, emit_bit, emit_cnt, emit_crc, go_eop;

    assign strobe     = (state != S_IDLE) && (cnt == CNT_LAST);
    assign stuff_due  = ((state == S_PID) || (state == S_DATA) || (state == S_CRC)) && (ones == STUFF_AT);
    assign field_last = (state == S_CRC) ? (bit_cnt == 5'd15) : (bit_cnt == 5'd7);

    assign D_Plus_Out  = dp_q;
    assign D_Minus_Out = dm_q;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sr_n      = sr;
        ones_n    = ones;
        bytes_n   = bytes_left;
        crc_n     = crc;
        pid_n     = pid_q;
        crc_en_n  = crc_en_q;
        nrzi_n    = nrzi_j;
        dp_n      = dp_q;
        dm_n      = dm_q;
        busy_n    = busy;
        done_n    = 1'b0;
        ready_n   = 1'b0;
        urun_n    = 1'b0;
        emit      = 1'b0;
        emit_bit  = 1'b0;
        emit_cnt  = 1'b0;
        emit_crc  = 1'b0;
        go_eop    = 1'b0;
        cnt_n     = (state == S_IDLE || strobe) ? '0 : cnt + CNT_W'(1);

        if (state == S_IDLE) begin
            // a start in the same cycle as done belongs to the packet just finished
            if (tx_start && !done) begin
                state_n   = S_SYNC;
                busy_n    = 1'b1;
                pid_n     = tx_pid;
                crc_en_n  = crc_en;
                bytes_n   = (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
                bit_cnt_n = '0;
                sr_n      = {8'h00, SYNC_BYTE};
                crc_n     = 16'hFFFF;
                ones_n    = '0;
                emit      = 1'b1;
                emit_bit  = SYNC_BYTE[0];
            end
        end else if (strobe) begin
            if (stuff_due) begin
                emit     = 1'b1;
                emit_bit = 1'b0;
            end else if (state == S_EOP) begin
                if (bit_cnt == EOP_LAST) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt_n == EOP_LAST) begin
                        dp_n = 1'b1;
                        dm_n = 1'b0;
                    end
                end
            end else if (!field_last) begin
                bit_cnt_n = bit_cnt + 5'd1;
                sr_n      = {1'b0, sr[15:1]};
                emit      = 1'b1;
                emit_bit  = sr[1];
                emit_cnt  = (state != S_SYNC);
                emit_crc  = (state == S_DATA);
            end else begin
                case (state)
                    S_SYNC: begin
                        state_n   = S_PID;
                        bit_cnt_n = '0;
                        sr_n      = {8'h00, pid_q};
                        emit      = 1'b1;
                        emit_bit  = pid_q[0];
                        emit_cnt  = 1'b1;
                    end
                    S_PID, S_DATA: begin
                        if (bytes_left != '0) begin
                            if (tx_valid) begin
                                state_n   = S_DATA;
                                bit_cnt_n = '0;
                                sr_n      = {8'h00, tx_data};
                                bytes_n   = bytes_left - LEN_W'(1);
                                ready_n   = 1'b1;
                                emit      = 1'b1;
                                emit_bit  = tx_data[0];
                                emit_cnt  = 1'b1;
                                emit_crc  = 1'b1;
                            end else begin
                                urun_n = 1'b1;
                                go_eop = 1'b1;
                            end
                        end else if (crc_en_q) begin
                            state_n   = S_CRC;
                            bit_cnt_n = '0;
                            sr_n      = ~crc;
                            emit      = 1'b1;
                            emit_bit  = ~crc[0];
                            emit_cnt  = 1'b1;
                        end else begin
                            go_eop = 1'b1;
                        end
                    end
                    default: go_eop = 1'b1;
                endcase
            end
        end

        if (go_eop) begin
            state_n   = S_EOP;
            bit_cnt_n = '0;
            dp_n      = 1'b0;
            dm_n      = 1'b0;
            nrzi_n    = 1'b1;
            ones_n    = '0;
        end

        // NRZI: a 0 toggles the line level, a 1 holds it
        if (emit) begin
            nrzi_n = emit_bit ? nrzi_j : ~nrzi_j;
            dp_n   = nrzi_n;
            dm_n   = ~nrzi_n;
            if (!emit_bit)
                ones_n = '0;
            else if (emit_cnt)
                ones_n = ones + ONES_W'(1);
        end

        if (emit_crc)
            crc_n = {1'b0, crc[15:1]} ^ (((crc[0] ^ emit_bit) != 1'b0) ? 16'hA001 : 16'h0000);
    end

    always_ff @(posedge clk or negedge N_reset) begin
        if (!N_reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            sr           <= '0;
            ones         <= '0;
            bytes_left   <= '0;
            crc          <= 16'hFFFF;
            pid_q        <= '0;
            crc_en_q     <= 1'b0;
            nrzi_j       <= 1'b1;
            dp_q         <= 1'b1;
            dm_q         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tx_ready     <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_cnt      <= bit_cnt_n;
            sr           <= sr_n;
            ones         <= ones_n;
            bytes_left   <= bytes_n;
            crc          <= crc_n;
            pid_q        <= pid_n;
            crc_en_q     <= crc_en_n;
            nrzi_j       <= nrzi_n;
            dp_q         <= dp_n;
            dm_q         <= dm_n;
            busy         <= busy_n;
            done         <= done_n;
            tx_ready     <= ready_n;
            err_underrun <= urun_n;
        end
    end
endmodule

// File: tb/tb_usb_tx_packet_engine.sv
// Bench for usb_tx_packet_engine: golden J/K/SE0 symbol stream per packet from a bit-level model, checked each bit time.
// A second instance at CLKS_PER_BIT=4 replays the ACK against a literal line pattern.
module tb_usb_tx_packet_engine;
    localparam int CPB   = 8;
    localparam int CPB4  = 4;
    localparam int LEN_W = 7;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic             clk = 1'b0;
    logic             N_reset;
    logic             tx_start, crc_en, tx_valid;
    logic [7:0]       tx_pid, tx_data;
    logic [LEN_W-1:0] tx_len;
    logic             tx_ready, busy, done, err_underrun, D_Plus_Out, D_Minus_Out;

    logic             tx_start4;
    logic             tx_ready4, busy4, done4, err_underrun4, dp4, dm4;

    usb_tx_packet_engine #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .N_reset(N_reset), .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len),
        .crc_en(crc_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .done(done), .err_underrun(err_underrun), .D_Plus_Out(D_Plus_Out), .D_Minus_Out(D_Minus_Out)
    );

    usb_tx_packet_engine #(.CLKS_PER_BIT(CPB4)) dut4 (
        .clk(clk), .N_reset(N_reset), .tx_start(tx_start4), .tx_pid(8'hD2), .tx_len(7'd0),
        .crc_en(1'b0), .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready4), .busy(busy4),
        .done(done4), .err_underrun(err_underrun4), .D_Plus_Out(dp4), .D_Minus_Out(dm4)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ready_cnt = 0;
    int         urun_cnt = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] pay[64];
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FWFT FIFO model: pop on the cycle tx_ready is high
    always @(negedge clk) begin
        if (tx_ready) begin
            ready_cnt++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (err_underrun) urun_cnt++;
        tx_valid = (fifo_q.size() != 0);
        tx_data  = tx_valid ? fifo_q[0] : 8'h00;
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input bit v);
        logic [15:0] r;
        r = {1'b0, c[15:1]};
        if ((c[0] ^ v) != 1'b0) r = r ^ 16'hA001;
        return r;
    endfunction

    task automatic build_expect(input logic [7:0] pid, input int len, input bit ce, input int avail);
        bit          raw[$];
        bit          dbits[$];
        int          ones, nsent;
        logic        lvl;
        logic [15:0] c;
        exp_q.delete();
        for (int i = 0; i < 8; i++) raw.push_back(i == 7);
        for (int i = 0; i < 8; i++) dbits.push_back(pid[i]);
        nsent = (avail < len) ? avail : len;
        c = 16'hFFFF;
        for (int b = 0; b < nsent; b++)
            for (int i = 0; i < 8; i++) begin
                dbits.push_back(pay[b][i]);
                c = crc_step(c, pay[b][i]);
            end
        if (ce && avail >= len)
            for (int i = 0; i < 16; i++) dbits.push_back(!c[i]);
        ones = 0;
        foreach (dbits[i]) begin
            raw.push_back(dbits[i]);
            if (dbits[i]) ones++; else ones = 0;
            if (ones == 6) begin
                raw.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        foreach (raw[i]) begin
            if (!raw[i]) lvl = !lvl;
            exp_q.push_back(lvl ? SYM_J : SYM_K);
        end
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endtask

    task automatic run_packet(input string name, input logic [7:0] pid, input int len, input bit ce,
                              input int avail, input int ign_idx);
        int         eff, nsent, idx;
        logic [1:0] sym;
        eff   = (len > 64) ? 64 : len;
        nsent = (avail < eff) ? avail : eff;
        fifo_q.delete();
        for (int b = 0; b < avail; b++) fifo_q.push_back(pay[b]);
        build_expect(pid, eff, ce, avail);
        @(negedge clk);
        ready_cnt = 0;
        urun_cnt  = 0;
        tx_pid    = pid;
        tx_len    = LEN_W'(len);
        crc_en    = ce;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk({name, "_busy_set"}, 32'(busy), 32'd1);
        idx = 0;
        while (exp_q.size() != 0) begin
            sym = exp_q.pop_front();
            chk($sformatf("%s_line%0d", name, idx), 32'({D_Plus_Out, D_Minus_Out}), 32'(sym));
            if (idx == ign_idx) begin
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (CPB - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
            idx++;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_busy_clr"}, 32'(busy), 32'd0);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk({name, "_start_at_done"}, 32'(busy), 32'd0);
        chk({name, "_idle_line"}, 32'({D_Plus_Out, D_Minus_Out}), 32'(SYM_J));
        chk({name, "_pops"}, 32'(ready_cnt), 32'(nsent));
        chk({name, "_underrun"}, 32'(urun_cnt), (avail < eff) ? 32'd1 : 32'd0);
    endtask

    task automatic run_ack4();
        logic [15:0] ack_k;
        logic [1:0]  sym;
        ack_k = 16'hE4D5;
        @(negedge clk);
        tx_start4 = 1'b1;
        @(negedge clk);
        tx_start4 = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (i < 16)      sym = ack_k[i] ? SYM_K : SYM_J;
            else if (i < 18) sym = SYM_SE0;
            else             sym = SYM_J;
            chk($sformatf("ack4_line%0d", i), 32'({dp4, dm4}), 32'(sym));
            repeat (CPB4) @(negedge clk);
        end
        chk("ack4_done", 32'(done4), 32'd1);
        chk("ack4_busy_clr", 32'(busy4), 32'd0);
        chk("ack4_no_pop", 32'(tx_ready4 | err_underrun4), 32'd0);
    endtask

    initial begin
        N_reset   = 1'b0;
        tx_start  = 1'b0;
        tx_start4 = 1'b0;
        tx_pid    = 8'h00;
        tx_len    = '0;
        crc_en    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dp", 32'(D_Plus_Out), 32'd1);
        chk("rst_dm", 32'(D_Minus_Out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({tx_ready, done, err_underrun}), 32'd0);
        N_reset = 1'b1;
        @(negedge clk);

        run_packet("ack", 8'hD2, 0, 1'b0, 0, 5);

        for (int i = 0; i < 4; i++) pay[i] = 8'(i);
        run_packet("data0", 8'hC3, 4, 1'b1, 4, -1);

        pay[0] = 8'hFF;
        run_packet("stuff", 8'hC3, 1, 1'b0, 1, -1);

        run_packet("data1_zero", 8'h4B, 0, 1'b1, 0, -1);

        pay[0] = 8'h5A;
        pay[1] = 8'hA5;
        run_packet("underrun", 8'hC3, 2, 1'b1, 1, -1);

        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom_range(0, 255));
        run_packet("clamp", 8'h4B, 100, 1'b1, 64, -1);

        for (int i = 0; i < 4; i++) pay[i] = 8'(i);
        fifo_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back(pay[i]);
        @(negedge clk);
        tx_pid   = 8'hC3;
        tx_len   = 7'd4;
        crc_en   = 1'b1;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        N_reset = 1'b0;
        #1;
        chk("midrst_dp", 32'(D_Plus_Out), 32'd1);
        chk("midrst_dm", 32'(D_Minus_Out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        N_reset = 1'b1;
        fifo_q.delete();
        @(negedge clk);
        run_packet("after_rst", 8'hC3, 4, 1'b1, 4, -1);

        run_ack4();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
